// File: rtl/lifo_1r1w.sv
// lifo_1r1w: ready/valid LIFO stack, one push and one pop per cycle.
// The top of stack is read asynchronously from the register array.
// A simultaneous push and pop replaces the top element in place.
module lifo_1r1w #(
    parameter int unsigned width_p      = 8,
    parameter int unsigned depth_log2_p = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    flush_i,
    input  logic [width_p-1:0]      data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic                    valid_o,
    output logic [width_p-1:0]      data_o,
    input  logic                    ready_i,
    output logic [depth_log2_p:0]   count_o
);

    localparam int unsigned depth_lp  = 1 << depth_log2_p;
    // Index is kept at least one bit wide so a single-entry stack still elaborates.
    localparam int unsigned idx_w_lp  = (depth_log2_p > 0) ? depth_log2_p : 1;
    localparam logic [depth_log2_p:0] depth_c   = (depth_log2_p+1)'(depth_lp);
    localparam logic [depth_log2_p:0] cnt_one_c = (depth_log2_p+1)'(1);

    logic [width_p-1:0]     mem_q [depth_lp];
    logic [depth_log2_p:0]  count_q, count_d;
    logic [idx_w_lp-1:0]    top_idx, push_idx, wr_idx;
    logic                   push, pop, we;

    assign ready_o  = (count_q != depth_c);
    assign valid_o  = (count_q != '0);
    assign count_o  = count_q;
    assign push     = valid_i & ready_o;
    assign pop      = valid_o & ready_i;
    assign top_idx  = idx_w_lp'(count_q - cnt_one_c);
    assign push_idx = idx_w_lp'(count_q);
    assign data_o   = valid_o ? mem_q[top_idx] : '0;

    // Next occupancy and write select; flush overrides any push or pop.
    always_comb begin
        count_d = count_q;
        we      = 1'b0;
        wr_idx  = push_idx;
        if (flush_i) begin
            count_d = '0;
        end else if (push && pop) begin
            we     = 1'b1;
            wr_idx = top_idx;
        end else if (push) begin
            we      = 1'b1;
            count_d = count_q + cnt_one_c;
        end else if (pop) begin
            count_d = count_q - cnt_one_c;
        end
    end

    // Occupancy register, cleared asynchronously.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule
